// File: rtl/dlfloat_pkg.sv
// Shared constants and types for the DLfloat16 MAC host interface.
package dlfloat_pkg;

  localparam int          DLF_W    = 16;
  localparam logic [15:0] DLF_ZERO = 16'h0000;
  localparam logic [15:0] DLF_NAN  = 16'hFFFF;

  // Device phase: operand A is framed in phase 0, operand B in phase 1.
  localparam logic PH_A = 1'b0;
  localparam logic PH_B = 1'b1;

  // Issue FSM state encoding.
  typedef logic [0:0] issue_state_t;
  localparam issue_state_t ST_IDLE   = 1'b0;
  localparam issue_state_t ST_SEND_B = 1'b1;

endpackage

// File: rtl/dlfloat_rsp_fifo.sv
// Synchronous first-word fall-through FIFO with occupancy count.
module dlfloat_rsp_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               rd_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_q, wr_d;
  logic [AW:0]  rd_q, rd_d;
  logic         do_push, do_pop;

  // Pointer arithmetic and status flags; the extra MSB separates full from empty.
  always_comb begin
    empty   = (wr_q == rd_q);
    full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    count   = wr_q - rd_q;
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    wr_d    = do_push ? wr_q + 1'b1 : wr_q;
    rd_d    = do_pop  ? rd_q + 1'b1 : rd_q;
    rd_data = empty ? '0 : mem[rd_q[AW-1:0]];
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage array write port.
  // NOTE: the data array is deliberately not reset; validity is carried by the
  // pointers alone, and rd_data is forced to zero while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/dlfloat_mac_host.sv
// Host master for the two-phase DLfloat16 MAC device pin protocol: frames
// operand pairs onto the pad bus and reassembles byte-serialised results.
module dlfloat_mac_host
  import dlfloat_pkg::*;
#(
  parameter int RES_LAT    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [DLF_W-1:0] req_a,
  input  logic [DLF_W-1:0] req_b,
  output logic [DLF_W-1:0] pad_data_out,
  input  logic [7:0]       pad_byte_in,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [DLF_W-1:0] rsp_data,
  output logic [2:0]       inflight
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  issue_state_t     state_q, state_d;
  logic             tx_phase_q, tx_phase_d;
  logic [DLF_W-1:0] pad_q, pad_d;
  logic [DLF_W-1:0] b_hold_q, b_hold_d;
  // Stage 0 is set in the cycle B is on the pads; stage RES_LAT is the head.
  logic [RES_LAT:0] tag_q, tag_d;
  logic [7:0]       hi_hold_q, hi_hold_d;
  logic             lo_pend_q, lo_pend_d;
  logic [2:0]       inflight_q, inflight_d;

  logic             accept, issue, push, pop, credit;
  logic             fifo_empty, fifo_full;
  logic [CW-1:0]    fifo_count;
  logic [3:0]       occupancy;

  // Issue handshake, credit and result-capture next-state logic.
  // NOTE: every always_comb output gets a default first so no path can hold
  // a previous value and infer a latch.
  always_comb begin
    state_d    = state_q;
    tx_phase_d = ~tx_phase_q;
    pad_d      = DLF_ZERO;
    b_hold_d   = b_hold_q;

    occupancy  = 4'(fifo_count) + 4'(inflight_q);
    credit     = occupancy < 4'(FIFO_DEPTH);
    req_ready  = (state_q == ST_IDLE) && (tx_phase_q == PH_B) && credit;
    accept     = req_valid && req_ready;
    issue      = (state_q == ST_SEND_B);

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          pad_d    = req_a;
          b_hold_d = req_b;
          state_d  = ST_SEND_B;
        end
      end
      ST_SEND_B: begin
        pad_d   = b_hold_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    tag_d      = {tag_q[RES_LAT-1:0], issue};
    hi_hold_d  = tag_q[RES_LAT] ? pad_byte_in : hi_hold_q;
    lo_pend_d  = tag_q[RES_LAT];
    push       = lo_pend_q;
    pop        = rsp_ready && !fifo_empty;
    inflight_d = inflight_q + 3'(issue) - 3'(push);
  end

  // State registers; everything clears on reset so no partial word survives.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      tx_phase_q <= PH_A;
      pad_q      <= DLF_ZERO;
      b_hold_q   <= DLF_ZERO;
      tag_q      <= '0;
      hi_hold_q  <= '0;
      lo_pend_q  <= 1'b0;
      inflight_q <= '0;
    end else begin
      state_q    <= state_d;
      tx_phase_q <= tx_phase_d;
      pad_q      <= pad_d;
      b_hold_q   <= b_hold_d;
      tag_q      <= tag_d;
      hi_hold_q  <= hi_hold_d;
      lo_pend_q  <= lo_pend_d;
      inflight_q <= inflight_d;
    end
  end

  dlfloat_rsp_fifo #(
    .W     (DLF_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({hi_hold_q, pad_byte_in}),
    .pop       (pop),
    .rd_data   (rsp_data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  assign pad_data_out = pad_q;
  assign rsp_valid    = !fifo_empty;
  assign inflight     = inflight_q;

endmodule

// File: tb/tb_dlfloat_mac_host.sv
// Bench for dlfloat_mac_host: a device stub returning A+B split into bytes,
// and a scoreboard of expected sums for every accepted pair.
module tb_dlfloat_mac_host;
  import dlfloat_pkg::*;

  localparam int RES_LAT    = 4;
  localparam int FIFO_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [15:0] req_a = '0;
  logic [15:0] req_b = '0;
  logic [15:0] pad_data_out;
  logic [7:0]  pad_byte_in = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_data;
  logic [2:0]  inflight;

  dlfloat_mac_host #(.RES_LAT(RES_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .pad_data_out (pad_data_out),
    .pad_byte_in  (pad_byte_in),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .inflight     (inflight)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  logic        ph;
  logic [15:0] a_cap = '0;
  bit   [7:0]  sched [int];
  logic [15:0] exp_q [$];
  logic [15:0] got_q [$];
  int          acc_cyc [$];
  bit          overflow_seen = 1'b0;
  bit          rand_ready = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) rsp_ready = 1'($urandom_range(0, 1));
  endtask

  // Device stub: phase counter shares rst_n with the host.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ph <= PH_A;
    else        ph <= ~ph;
  end

  always @(negedge rst_n) sched.delete();

  // Stub output bus: byte scheduled for this cycle, else zero.
  always @(posedge clk) begin
    cyc++;
    #1;
    pad_byte_in = (rst_n && sched.exists(cyc)) ? sched[cyc] : 8'h00;
  end

  // Stub input capture: A in phase 0, B in phase 1, result hi/lo RES_LAT later.
  always @(negedge clk) begin
    logic [15:0] sum;
    if (rst_n) begin
      if (ph == PH_A) a_cap = pad_data_out;
      else begin
        sum = a_cap + pad_data_out;
        sched[cyc + RES_LAT]     = sum[15:8];
        sched[cyc + RES_LAT + 1] = sum[7:0];
      end
    end
  end

  // Scoreboard: every accepted pair must come back as its sum, in order.
  always @(negedge clk) begin
    if (rst_n) begin
      if (req_valid && req_ready) begin
        exp_q.push_back(16'(req_a + req_b));
        acc_cyc.push_back(cyc);
      end
      if (rsp_valid && rsp_ready) begin
        got_q.push_back(rsp_data);
        if (exp_q.size() == 0) check("pop_unexpected", rsp_valid, 1'b0);
        else                   check("rsp_data", rsp_data, exp_q.pop_front());
      end
      if (dut.push && dut.fifo_full) overflow_seen = 1'b1;
    end
  end

  task automatic send_pair(input logic [15:0] a, input logic [15:0] b);
    int w = 0;
    req_a = a;
    req_b = b;
    req_valid = 1'b1;
    while (!req_ready && w < 40) begin
      tick();
      w++;
    end
    if (w >= 40) check("req_ready_timeout", req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while ((exp_q.size() != 0 || rsp_valid) && w < 100) begin
      tick();
      w++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit ready_seen;
    bit stale;
    int w;

    // T1: reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_pad", pad_data_out, 16'h0000);
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_data", rsp_data, 16'h0000);
    check("rst_inflight", inflight, 3'd0);
    rst_n = 1'b1;
    tick();
    check("idle_pad", pad_data_out, 16'h0000);

    // T2: single pair and result latency
    send_pair(16'h3E00, 16'h4000);
    check("t2_pad_a", pad_data_out, 16'h3E00);
    check("t2_a_phase", ph, PH_A);
    tick();
    check("t2_pad_b", pad_data_out, 16'h4000);
    check("t2_inflight_1", inflight, 3'd1);
    repeat (RES_LAT + 1) tick();
    check("t2_not_yet_valid", rsp_valid, 1'b0);
    tick();
    check("t2_valid_on_time", rsp_valid, 1'b1);
    check("t2_data", rsp_data, 16'h7E00);
    check("t2_inflight_0", inflight, 3'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("t2_popped", rsp_valid, 1'b0);

    // T3: back-to-back stream with the consumer always ready
    rsp_ready = 1'b1;
    got_q.delete();
    acc_cyc.delete();
    send_pair(16'h0001, 16'h0002);
    send_pair(16'h00FF, 16'h0001);
    send_pair(DLF_NAN, 16'h0000);
    drain();
    check("t3_count", got_q.size(), 3);
    check("t3_res0", got_q[0], 16'h0003);
    check("t3_res1", got_q[1], 16'h0100);
    check("t3_res2_nan", got_q[2], DLF_NAN);
    check("t3_cadence0", acc_cyc[1] - acc_cyc[0], 2);
    check("t3_cadence1", acc_cyc[2] - acc_cyc[1], 2);

    // T4: credit backpressure with the consumer stalled
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_pair(16'($urandom), 16'($urandom));
    ready_seen = 1'b0;
    repeat (16) begin
      tick();
      if (req_ready) ready_seen = 1'b1;
    end
    check("t4_no_credit", ready_seen, 1'b0);
    check("t4_fifo_full", dut.fifo_count, 3'd4);
    check("t4_inflight_0", inflight, 3'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    w = 0;
    while (!req_ready && w < 4) begin
      tick();
      w++;
    end
    check("t4_ready_back", req_ready, 1'b1);
    check("t4_ready_phase", ph, PH_B);
    rsp_ready = 1'b1;
    drain();

    // T5: reset during SEND_B with two results queued
    rsp_ready = 1'b0;
    send_pair(16'h1111, 16'h2222);
    send_pair(16'h3333, 16'h4444);
    repeat (12) tick();
    check("t5_queued", dut.fifo_count, 3'd2);
    send_pair(16'h5555, 16'h6666);
    check("t5_in_send_b", dut.state_q, ST_SEND_B);
    rst_n = 1'b0;
    exp_q.delete();
    tick();
    check("t5_rsp_valid", rsp_valid, 1'b0);
    check("t5_inflight", inflight, 3'd0);
    check("t5_pad", pad_data_out, 16'h0000);
    tick();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    stale = 1'b0;
    repeat (20) begin
      tick();
      if (rsp_valid) stale = 1'b1;
    end
    check("t5_no_stale", stale, 1'b0);
    check("t5_inflight_after", inflight, 3'd0);

    // T6: request raised in phase 0 waits for phase 1
    if (ph != PH_A) tick();
    req_a = 16'h0A0A;
    req_b = 16'h0505;
    req_valid = 1'b1;
    check("t6_phase0_not_ready", req_ready, 1'b0);
    tick();
    check("t6_phase1", ph, PH_B);
    check("t6_ready", req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
    check("t6_pad_a", pad_data_out, 16'h0A0A);
    check("t6_a_phase", ph, PH_A);
    tick();
    check("t6_pad_b", pad_data_out, 16'h0505);
    drain();

    // Randomised stream with random consumer stalls; NaN operands forwarded.
    rand_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      if (i % 6 == 0) send_pair(DLF_NAN, 16'h0000);
      else            send_pair(16'($urandom), 16'($urandom));
    end
    rand_ready = 1'b0;
    rsp_ready = 1'b1;
    drain();
    check("final_inflight", inflight, 3'd0);
    check("no_push_when_full", overflow_seen, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
